// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per cycle.
// Optional two's-complement input: magnitude is converted, sign reported on neg.
module seq_bin2bcd #(
   parameter int W = 12,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   bin,
   input  logic           signed_mode,
   output logic           ready,
   output logic           busy,
   output logic           done,
   output logic [4*N-1:0] bcd,
   output logic           neg,
   output logic           ovf
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t         state, state_next;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   mag;
   logic [4*N-1:0] work, work_adj, work_next;
   logic           ovf_acc, ovf_next, sign, last;

   // Add 3 to every digit >= 5 so the following shift carries correctly into the next digit.
   function automatic logic [4*N-1:0] add3(input logic [4*N-1:0] v);
      logic [4*N-1:0] r;
      r = v;
      for (int i = 0; i < N; i++) begin
         if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   always_comb begin
      work_adj  = add3(work);
      work_next = {work_adj[4*N-2:0], mag[W-1]};
      ovf_next  = ovf_acc | work_adj[4*N-1];
      last      = (cnt == CW'(1));
   end

   always_comb begin
      state_next = state;
      ready      = (state == IDLE);
      busy       = (state == SHIFT);
      case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         mag     <= '0;
         work    <= '0;
         ovf_acc <= 1'b0;
         sign    <= 1'b0;
         bcd     <= '0;
         neg     <= 1'b0;
         ovf     <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude.
                  mag     <= (signed_mode && bin[W-1]) ? (~bin + W'(1)) : bin;
                  sign    <= signed_mode & bin[W-1];
                  work    <= '0;
                  ovf_acc <= 1'b0;
                  cnt     <= CW'(W);
               end
            end
            SHIFT: begin
               work    <= work_next;
               mag     <= {mag[W-2:0], 1'b0};
               ovf_acc <= ovf_next;
               cnt     <= cnt - CW'(1);
               if (last) begin
                  bcd  <= work_next;
                  neg  <= sign;
                  ovf  <= ovf_next;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/seq_bin2bcd.md
SEQ_BIN2BCD -- requirements
Module: seq_bin2bcd

Interface
REQ-001 SHALL have parameter W, default 12, meaning binary operand width (legal W >= 2).
REQ-002 SHALL have parameter N, default 4, meaning number of BCD output digits (legal N >= 1).
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to convert bin.
REQ-006 SHALL have port bin, input, W bits: operand, sampled only on the accepting edge.
REQ-007 SHALL have port signed_mode, input, 1 bit: 1 means bin is two's complement; sampled with bin.
REQ-008 SHALL have port ready, output, 1 bit: high when a start will be accepted.
REQ-009 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse when results become valid.
REQ-011 SHALL have port bcd, output, 4*N bits: result digits; digit i is in bits [4i+3:4i], with digit 0 least significant.
REQ-012 SHALL have port neg, output, 1 bit: result sign; 1 means the operand was negative.
REQ-013 SHALL have port ovf, output, 1 bit: magnitude does not fit in N digits.

Function
REQ-014 SHALL implement an FSM with states IDLE and SHIFT; ready = (state == IDLE); busy = (state == SHIFT).
REQ-015 In IDLE with start=1 at an edge: SHALL capture the operand, clear the working BCD register and ovf accumulator, load bit counter = W, and go to SHIFT.
REQ-016 Operand capture: if signed_mode=1 and bin[W-1]=1, SHALL store the magnitude as the W-bit two's-complement negation, set internal sign=1; otherwise store bin unchanged, sign=0.
REQ-017 Operand capture: -2^(W-1) SHALL yield magnitude 2^(W-1) as W-bit unsigned, with no error.
REQ-018 Each SHIFT edge SHALL first add 3 to every one of the N working digits that is >= 5, including the top digit.
REQ-019 Each SHIFT edge SHALL then shift the {BCD, magnitude} register left by one, moving the magnitude MSB into BCD bit 0.
REQ-020 Each SHIFT edge SHALL OR the bit shifted out of BCD bit 4N-1 into the ovf accumulator, and decrement the counter.
REQ-021 When the counter reaches 0 on a SHIFT edge, that same edge SHALL update bcd, neg and ovf, assert done, and return to IDLE.
REQ-022 Latency: with a start accepted at edge k, done SHALL be high exactly during the cycle following edge k+W, and SHALL be low at every other time.
REQ-023 bcd, neg and ovf SHALL hold their last values until the next completion; they SHALL NOT change on accept or mid-conversion.
REQ-024 When ovf=1, bcd SHALL hold the low N digits of the decimal result; that value is undefined for use, but it SHALL be deterministic.
REQ-025 A zero result SHALL give neg=0, including the signed input 0.
REQ-026 start while busy SHALL be ignored with no queuing; start in the done cycle (state IDLE) SHALL be accepted.
REQ-027 Changes to bin or signed_mode after the accepting edge SHALL NOT affect the conversion in progress.
REQ-028 Back-to-back conversions SHALL sustain one result per W+1 cycles.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, counter=0, working registers=0, bcd=0, neg=0, ovf=0 and done=0; ready=1 and busy=0 while rst=1 and after release.
REQ-030 rst asserted mid-conversion SHALL abort it; no done pulse for that operand, and outputs SHALL read 0.
REQ-031 The first edge after rst deasserts SHALL be able to accept a start.

Verification (W=12, N=4 unless noted)
REQ-032 bin=12'd4095, signed_mode=0, start at edge k -> done only in the cycle after edge k+12; bcd=16'h4095, neg=0, ovf=0.
REQ-033 bin=12'h800, signed_mode=1 -> bcd=16'h2048, neg=1; bin=12'hFFF, signed_mode=1 -> bcd=16'h0001, neg=1; bin=0, signed_mode=1 -> bcd=0, neg=0.
REQ-034 N=3: bin=12'd1000 -> ovf=1; bin=12'd999 -> bcd=12'h999, ovf=0.
REQ-035 Start bin=12'd123, pulse start with bin=12'd456 at edge k+5 -> single done at edge k+12 with bcd=16'h0123; start in the done cycle with 12'd456 -> bcd=16'h0456 twelve cycles later.
REQ-036 Assert rst asynchronously at edge k+6 (mid-cycle) -> bcd=0, busy=0 immediately, no done pulse; a new start for 12'd78 after release -> bcd=16'h0078.
REQ-037 Exhaustive sweep: all 4096 inputs in both modes -> results match the decimal reference model, with one done per start.
